gmii_tx_arbiter: RTL and testbench

GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

---
 rtl/gmii_tx_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// gmii_tx_arbiter
//
// Shares a single GMII transmit path between two frame sources. It grants one
// source at a time, round-robin under contention, and forwards that source's
// tx_en/txd with one register stage. It also enforces:
//   - a start timeout while waiting for the granted source to begin a frame,
//   - a maximum frame length (the frame is cut and abort is pulsed), and
//   - a minimum inter-frame gap before the next grant.
//
// Ports
//   gmii_txc              clock, all logic on the rising edge
//   rst                   synchronous active-high reset
//   req0/req1             per-source request for transmit access
//   grant0/grant1         registered grant, one-hot or zero
//   src0_tx_en/src1_tx_en per-source GMII frame enable
//   src0_txd/src1_txd     per-source GMII data
//   gmii_tx_en/gmii_txd   registered merged GMII output
//   busy                  high whenever the arbiter is not idle
//   abort                 one-cycle pulse when a frame is cut at MAX_LEN
// -----------------------------------------------------------------------------
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1530,
  parameter int START_TO   = 16
) (
  input  logic       gmii_txc,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       grant0,
  output logic       grant1,
  input  logic       src0_tx_en,
  input  logic       src1_tx_en,
  input  logic [7:0] src0_txd,
  input  logic [7:0] src1_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       abort
);

  localparam int DATA_W = 8;
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int IFG_W  = $clog2(IFG_CYCLES + 1);
  localparam int TO_W   = $clog2(START_TO + 1);
  // The SEND cycle in which the source drops tx_en is already the first gap
  // cycle, so the IFG state itself lasts IFG_CYCLES-1 cycles.
  localparam int IFG_LAST = (IFG_CYCLES >= 2) ? IFG_CYCLES - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SEND  = 3'd2,
    S_DRAIN = 3'd3,
    S_IFG   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;   // currently granted source
  logic              ptr_q, ptr_d;     // source favoured on a tie
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IFG_W-1:0]  ifg_q, ifg_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        grant_q, grant_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic              abort_q, abort_d;

  logic              sel_en, sel_req;

  // Control decisions use the source that already holds the grant.
  assign sel_en  = port_q ? src1_tx_en : src0_tx_en;
  assign sel_req = port_q ? req1 : req0;

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    ifg_d   = ifg_q;
    to_d    = to_q;
    abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          port_d  = (req0 && req1) ? ptr_q : req1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sel_en) begin
          state_d = S_SEND;
        end else if (!sel_req || (to_q == TO_W'(START_TO - 1))) begin
          state_d = S_IDLE;
          ptr_d   = ~port_q;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_SEND: begin
        // len_q counts output tx_en cycles after the one produced on WAIT
        // exit, so hitting MAX_LEN-1 here means MAX_LEN bytes are already out.
        if (!sel_en) begin
          state_d = S_IFG;
          ptr_d   = ~port_q;
        end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
          state_d = S_DRAIN;
          abort_d = 1'b1;
        end else begin
          len_d = len_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!sel_en) begin
          state_d = S_IFG;
          ptr_d   = ~port_q;
        end
      end
      S_IFG: begin
        if (ifg_q == IFG_W'(IFG_LAST)) begin
          state_d = S_IDLE;
        end else begin
          ifg_d = ifg_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every counter starts from zero in whichever state is entered.
    if (state_d != state_q) begin
      len_d = '0;
      ifg_d = '0;
      to_d  = '0;
    end

    grant_d = 2'b00;
    if (state_d == S_WAIT || state_d == S_SEND || state_d == S_DRAIN) begin
      grant_d = port_d ? 2'b10 : 2'b01;
    end

    // The output register only carries source data for cycles spent in
    // WAIT or SEND; every other state (including DRAIN after a cut) shows zero.
    tx_en_d = 1'b0;
    txd_d   = '0;
    if (state_d == S_WAIT || state_d == S_SEND) begin
      tx_en_d = port_d ? src1_tx_en : src0_tx_en;
      txd_d   = port_d ? src1_txd : src0_txd;
    end
  end

  always_ff @(posedge gmii_txc) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      ptr_q   <= 1'b0;
      len_q   <= '0;
      ifg_q   <= '0;
      to_q    <= '0;
      grant_q <= 2'b00;
      tx_en_q <= 1'b0;
      txd_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      ifg_q   <= ifg_d;
      to_q    <= to_d;
      grant_q <= grant_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      abort_q <= abort_d;
    end
  end

  assign grant0     = grant_q[0];
  assign grant1     = grant_q[1];
  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign busy       = (state_q != S_IDLE);
  assign abort      = abort_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for gmii_tx_arbiter. Stimulus is laid out as an absolute cycle
// timeline. Expected outputs are produced from per-grant timelines: a grant
// window, a window in which the output mirrors the granted source one cycle
// late, and a busy window. One process compares every output on every cycle.
// Literal checks at the end pin key cycle numbers and counts.
// Cycle c is the interval after rising edge c; inputs for cycle c are applied
// just after edge c, and outputs are sampled on the falling edge in cycle c.
// -----------------------------------------------------------------------------
module tb_gmii_tx_arbiter;
  localparam int N    = 2600;
  localparam int IFG  = 12;
  localparam int MAXL = 1530;
  localparam int STO  = 16;

  logic       clk;
  logic       rst, req0, req1, en0, en1;
  logic [7:0] d0, d1;
  logic       g0, g1, tx_en, busy, abort;
  logic [7:0] txd;

  gmii_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL), .START_TO(STO)) dut (
    .gmii_txc(clk), .rst(rst), .req0(req0), .req1(req1),
    .grant0(g0), .grant1(g1),
    .src0_tx_en(en0), .src1_tx_en(en1), .src0_txd(d0), .src1_txd(d1),
    .gmii_tx_en(tx_en), .gmii_txd(txd), .busy(busy), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit         drv_rst [N];
  bit         drv_req [2][N];
  bit         drv_en  [2][N];
  logic [7:0] drv_d   [2][N];

  bit         exp_g   [2][N];
  bit         exp_en  [N];
  bit         exp_busy[N];
  bit         exp_ab  [N];
  logic [7:0] exp_d   [N];

  bit         obs_g   [2][N];
  bit         obs_en  [N];
  bit         obs_busy[N];
  bit         obs_ab  [N];
  logic [7:0] obs_d   [N];

  int checks = 0;
  int errors = 0;

  task automatic req_on(input int p, input int a, input int b);
    for (int c = a; c <= b; c++) drv_req[p][c] = 1'b1;
  endtask

  task automatic src_frame(input int p, input int s, input int len, input int base);
    for (int i = 0; i < len; i++) begin
      drv_en[p][s+i] = 1'b1;
      drv_d[p][s+i]  = 8'((base + i) & 255);
    end
  endtask

  // Request seen in IDLE during cycle r: grant in r+1..gend, the output mirrors
  // the source one cycle late in r+1..cut, busy in r+1..bend.
  task automatic exp_win(input int p, input int r, input int gend, input int cut,
                         input int bend);
    for (int c = r + 1; c <= gend; c++) exp_g[p][c] = 1'b1;
    for (int c = r + 1; c <= bend; c++) exp_busy[c] = 1'b1;
    for (int c = r + 1; c <= cut; c++) begin
      exp_en[c] = drv_en[p][c-1];
      exp_d[c]  = drv_d[p][c-1];
    end
  endtask

  task automatic build();
    for (int c = 0; c < N; c++) begin
      drv_d[0][c] = 8'h00;
      drv_d[1][c] = 8'h00;
      exp_d[c]    = 8'h00;
    end
    for (int c = 0; c <= 2; c++) drv_rst[c] = 1'b1;

    // Single request: req at 5, frame 7..70.
    req_on(0, 5, 7);
    src_frame(0, 7, 64, 1);
    exp_win(0, 5, 71, 71, 70 + IFG);

    // Start timeout on port 1: source never starts.
    req_on(1, 90, 106);
    exp_win(1, 90, 90 + STO, 90 + STO, 90 + STO);

    // Contention: both request, 64-byte frames, grants alternate 0,1,0,1.
    req_on(0, 120, 278);
    req_on(1, 120, 356);
    for (int k = 0; k < 4; k++) begin
      int r;
      r = 120 + 78 * k;
      src_frame(k % 2, r + 2, 64, 16 * k + 1);
      exp_win(k % 2, r, r + 66, r + 66, r + 65 + IFG);
    end

    // Oversize frame: 2000 cycles at 442..2441, cut after MAXL bytes.
    req_on(0, 440, 442);
    src_frame(0, 442, 2000, 0);
    exp_win(0, 440, 2442, 442 + MAXL, 2441 + IFG);
    exp_ab[442 + MAXL + 1] = 1'b1;

    // Isolation: port 1 toggles with random data while port 0 sends.
    req_on(0, 2460, 2462);
    src_frame(0, 2462, 40, 8'hA0);
    for (int c = 2455; c <= 2510; c++) begin
      drv_en[1][c] = 1'($urandom_range(0, 1));
      drv_d[1][c]  = 8'($urandom);
    end
    exp_win(0, 2460, 2502, 2502, 2501 + IFG);

    // Reset 30 cycles into a frame; the pending req0 is granted again.
    req_on(0, 2520, 2556);
    src_frame(0, 2522, 30, 8'h55);
    drv_rst[2552] = 1'b1;
    drv_rst[2553] = 1'b1;
    exp_win(0, 2520, 2552, 2552, 2552);
    src_frame(0, 2556, 10, 8'hC0);
    exp_win(0, 2554, 2566, 2566, 2565 + IFG);
  endtask

  task automatic chk(input string nm, input int c, input logic [7:0] act,
                     input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, want);
    end
  endtask

  task automatic lit(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  // Driver
  initial begin
    build();
    for (int c = 0; c < N; c++) begin
      rst  = drv_rst[c];
      req0 = drv_req[0][c];
      req1 = drv_req[1][c];
      en0  = drv_en[0][c];
      en1  = drv_en[1][c];
      d0   = drv_d[0][c];
      d1   = drv_d[1][c];
      @(posedge clk);
      #1;
    end
  end

  // Compare
  initial begin
    int cnt, seq, run, mingap;
    bit seen;
    for (int c = 1; c < N; c++) begin
      @(negedge clk);
      obs_g[0][c] = g0;
      obs_g[1][c] = g1;
      obs_en[c]   = tx_en;
      obs_busy[c] = busy;
      obs_ab[c]   = abort;
      obs_d[c]    = txd;
      chk("grant0", c, {7'd0, g0}, {7'd0, exp_g[0][c]});
      chk("grant1", c, {7'd0, g1}, {7'd0, exp_g[1][c]});
      chk("gmii_tx_en", c, {7'd0, tx_en}, {7'd0, exp_en[c]});
      chk("gmii_txd", c, txd, exp_d[c]);
      chk("busy", c, {7'd0, busy}, {7'd0, exp_busy[c]});
      chk("abort", c, {7'd0, abort}, {7'd0, exp_ab[c]});
    end

    // Reset state and single-request timeline.
    lit("reset_grant0", int'(obs_g[0][2]), 0);
    lit("reset_busy", int'(obs_busy[3]), 0);
    lit("single_grant_first", int'(obs_g[0][6]), 1);
    lit("single_grant_last", int'(obs_g[0][71]), 1);
    lit("single_grant_off", int'(obs_g[0][72]), 0);
    lit("single_en_before", int'(obs_en[7]), 0);
    lit("single_en_first", int'(obs_en[8]), 1);
    lit("single_en_after", int'(obs_en[72]), 0);
    lit("single_txd_first", int'(obs_d[8]), 8'h01);
    lit("single_txd_last", int'(obs_d[71]), 8'h40);
    lit("single_busy_end", int'(obs_busy[82]), 1);
    lit("single_busy_low", int'(obs_busy[83]), 0);

    // Start timeout: grant1 lasts exactly 16 cycles.
    cnt = 0;
    for (int c = 88; c <= 112; c++) cnt += int'(obs_g[1][c]);
    lit("timeout_grant1_cycles", cnt, 16);

    // Contention: grant order and minimum output gap.
    seq = 0;
    for (int c = 118; c <= 440; c++) begin
      if (obs_g[0][c] && !obs_g[0][c-1]) seq = seq * 10 + 1;
      if (obs_g[1][c] && !obs_g[1][c-1]) seq = seq * 10 + 2;
    end
    lit("contention_order", seq, 1212);
    run = 0;
    mingap = 1000;
    seen = 1'b0;
    for (int c = 120; c <= 440; c++) begin
      if (obs_en[c]) begin
        if (seen && run > 0 && run < mingap) mingap = run;
        seen = 1'b1;
        run = 0;
      end else begin
        run++;
      end
    end
    lit("contention_min_gap", mingap, 14);

    // Oversize frame.
    cnt = 0;
    for (int c = 440; c <= 2458; c++) cnt += int'(obs_en[c]);
    lit("oversize_en_cycles", cnt, 1530);
    cnt = 0;
    for (int c = 440; c <= 2458; c++) cnt += int'(obs_ab[c]);
    lit("oversize_abort_pulses", cnt, 1);
    lit("oversize_abort_cycle", int'(obs_ab[1973]), 1);
    lit("oversize_grant_held", int'(obs_g[0][2442]), 1);
    lit("oversize_grant_off", int'(obs_g[0][2443]), 0);
    lit("oversize_busy_end", int'(obs_busy[2453]), 1);
    lit("oversize_busy_low", int'(obs_busy[2454]), 0);

    // Isolation.
    lit("isolation_txd_first", int'(obs_d[2463]), 8'hA0);
    lit("isolation_txd_last", int'(obs_d[2502]), 8'hC7);

    // Reset mid-frame.
    lit("midreset_en_before", int'(obs_en[2552]), 1);
    lit("midreset_en", int'(obs_en[2553]), 0);
    lit("midreset_grant", int'(obs_g[0][2553]), 0);
    lit("midreset_busy", int'(obs_busy[2553]), 0);
    lit("midreset_regrant", int'(obs_g[0][2555]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
